// File: rtl/fifo_arb_pkg.sv
// Shared types, default constants and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_TIMEOUT   = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotates req_valid so rr_ptr lands on bit 0, takes the
// lowest set bit, then rotates the index back into producer numbering.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   pick,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot_s;

  // Rotate, priority-encode and unrotate in one combinational pass
  always_comb begin
    int idx;
    int off;
    int abs_idx;
    rot_s   = '0;
    idx     = 0;
    off     = 0;
    abs_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      rot_s[k] = req_valid[idx];
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off = k;
      end else begin
        off = off;
      end
    end
    abs_idx = int'(rr_ptr) + off;
    if (abs_idx >= NUM_REQ) begin
      abs_idx = abs_idx - NUM_REQ;
    end else begin
      abs_idx = abs_idx;
    end
    pick    = PTR_W'(abs_idx);
    any_req = |rot_s;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port between NUM_REQ producers.
// Optional idle-owner grant revocation is enabled by defining FIFO_WR_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
`ifdef FIFO_WR_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      wr,
  output logic [DATA_W-1:0]         data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef FIFO_WR_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_evt
`endif
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST) + 1;

  arb_state_e         state_r;
  arb_state_e         state_nxt_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   owner_r;
  logic [PTR_W-1:0]   owner_inc_s;
  logic [PTR_W-1:0]   pick_s;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic               any_req_s;
  logic               own_valid_s;
  logic               accept_s;
  logic               burst_end_s;
  logic               revoke_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_r),
    .pick      (pick_s),
    .any_req   (any_req_s)
  );

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT) + 1;

  logic [TO_W-1:0] idle_cnt_r;
  logic            timeout_evt_r;

  // Idle-owner counter and the one-cycle revocation pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r    <= '0;
      timeout_evt_r <= 1'b0;
    end else begin
      timeout_evt_r <= revoke_s;
      if ((state_r != BURST) || accept_s) begin
        idle_cnt_r <= '0;
      end else if (!own_valid_s) begin
        idle_cnt_r <= idle_cnt_r + TO_W'(1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  assign timeout_evt = timeout_evt_r;
`endif

  // Owner handshake decode; rst gates the strobe so an abandoned burst never writes
  always_comb begin
    own_valid_s = req_valid[owner_r];
    accept_s    = (state_r == BURST) & own_valid_s & ~fifo_full & ~rst;
    burst_end_s = accept_s & (req_last[owner_r] | (beat_cnt_r == CNT_W'(MAX_BURST - 1)));
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    revoke_s    = (state_r == BURST) & ~own_valid_s & (idle_cnt_r == TO_W'(TIMEOUT - 1));
`else
    revoke_s    = 1'b0;
`endif
    if (owner_r == PTR_W'(NUM_REQ - 1)) begin
      owner_inc_s = '0;
    end else begin
      owner_inc_s = owner_r + PTR_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (burst_end_s || revoke_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, owner, beat counter and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && any_req_s) begin
        owner_r    <= pick_s;
        beat_cnt_r <= '0;
      end else if (accept_s) begin
        owner_r    <= owner_r;
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
        owner_r    <= owner_r;
        beat_cnt_r <= beat_cnt_r;
      end
      if (burst_end_s || revoke_s) begin
        rr_ptr_r <= owner_inc_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Output decode: only the owner sees ready, and only while the FIFO has room
  always_comb begin
    grant     = '0;
    req_ready = '0;
    busy      = 1'b0;
    wr        = 1'b0;
    data_in   = '0;
    if (state_r == BURST) begin
      grant[owner_r]     = 1'b1;
      req_ready[owner_r] = ~fifo_full & ~rst;
      busy               = 1'b1;
      wr                 = accept_s;
      data_in            = req_data[owner_r*DATA_W +: DATA_W];
    end else begin
      grant = '0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive the requests,
// a negedge monitor pops expected writes and grants as the DUT presents them.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           wr;
  logic [W-1:0]   data_in;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
  logic           timeout_evt;
`endif

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .wr        (wr),
    .data_in   (data_in),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    ,
    .timeout_evt (timeout_evt)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0]   pq [N][$];
  logic [7:0]   exp_wr [$];
  logic [N-1:0] exp_grant [$];
  int           checks = 0;
  int           errors = 0;
  logic         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int p, input logic last, input logic [7:0] d);
    pq[p].push_back({last, d});
  endtask

  // Producer model: retire accepted beats, present the next head beat
  initial begin
    logic [N-1:0] acc;
    logic [8:0]   head;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] === 1'b1 && pq[i].size() > 0) void'(pq[i].pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() > 0) begin
          head = pq[i][0];
          req_valid[i]        = 1'b1;
          req_data[i*W +: W]  = head[7:0];
          req_last[i]         = head[8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every write and every new grant against the scoreboard
  initial begin
    logic [N-1:0] prev_grant;
    logic [7:0]   e;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (wr === 1'b1) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr actual=%0h required=none", data_in);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_data", data_in, e);
          end
        end
        if (grant !== prev_grant && grant !== '0) begin
          chk("idle_gap", prev_grant, 0);
          chk("grant_onehot", $onehot(grant), 1);
          if (exp_grant.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant actual=%0h required=none", grant);
          end else begin
            chk("grant_order", grant, exp_grant.pop_front());
          end
        end
      end
      prev_grant = grant;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic wait_write(input logic [7:0] d);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (wr === 1'b1 && data_in === d) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_write", found, 1);
  endtask

  task automatic drain(input int max);
    logic done;
    logic empty;
    done = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      empty = (exp_wr.size() == 0) && (exp_grant.size() == 0);
      for (int i = 0; i < N; i++) if (pq[i].size() != 0) empty = 1'b0;
      if (empty && grant === '0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    logic seen;
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", data_in, 0);
    @(posedge clk); #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single producer, three beats, last on the third
    @(posedge clk); #2;
    push(0, 1'b0, 8'hA1); push(0, 1'b0, 8'hA2); push(0, 1'b1, 8'hA3);
    exp_wr.push_back(8'hA1); exp_wr.push_back(8'hA2); exp_wr.push_back(8'hA3);
    exp_grant.push_back(4'b0001);
    @(negedge clk);
    @(negedge clk);
    chk("arb_cycle_wr", wr, 0);
    chk("arb_cycle_grant", grant, 0);
    @(negedge clk);
    chk("first_beat_wr", wr, 1);
    chk("first_beat_grant", grant, 4'b0001);
    drain(100);

    // rr_ptr is now 1: producer 1 wins over producer 0
    @(posedge clk); #2;
    push(0, 1'b1, 8'hB0); push(1, 1'b1, 8'hB1);
    exp_grant.push_back(4'b0010); exp_grant.push_back(4'b0001);
    exp_wr.push_back(8'hB1); exp_wr.push_back(8'hB0);
    drain(100);

    // All four producers streaming without last: MAX_BURST rotation
    do_reset();
    @(posedge clk); #2;
    for (int b = 0; b < 8; b++) push(0, 1'b0, 8'(b));
    for (int p = 1; p < N; p++) for (int b = 0; b < 4; b++) push(p, 1'b0, 8'(p * 16 + b));
    for (int p = 0; p < N; p++) begin
      exp_grant.push_back(4'(1 << p));
      for (int b = 0; b < 4; b++) exp_wr.push_back(8'(p * 16 + b));
    end
    exp_grant.push_back(4'b0001);
    for (int b = 4; b < 8; b++) exp_wr.push_back(8'(b));
    drain(400);

    // FIFO full for five cycles on beat 2 of producer 1
    do_reset();
    @(posedge clk); #2;
    for (int b = 0; b < 4; b++) push(1, 1'b0, 8'(8'h10 + b));
    push(1, 1'b1, 8'h14);
    for (int b = 0; b < 5; b++) exp_wr.push_back(8'(8'h10 + b));
    exp_grant.push_back(4'b0010); exp_grant.push_back(4'b0010);
    wait_write(8'h11);
    @(posedge clk); #2;
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("full_wr", wr, 0);
      chk("full_ready", req_ready[1], 0);
      chk("full_grant", grant, 4'b0010);
    end
    @(posedge clk); #2;
    fifo_full = 1'b0;
    @(negedge clk);
    chk("resume_wr", wr, 1);
    chk("resume_data", data_in, 8'h12);
    drain(100);

    // Reset pulsed mid-burst of producer 2
    do_reset();
    @(posedge clk); #2;
    for (int b = 0; b < 4; b++) push(2, 1'b0, 8'(8'h20 + b));
    exp_wr.push_back(8'h20);
    exp_grant.push_back(4'b0100);
    wait_write(8'h20);
    @(posedge clk); #2;
    rst = 1'b1;
    pq[2].delete();
    @(negedge clk);
    chk("rst_cycle_wr", wr, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", grant, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wr", wr, 0);
    @(posedge clk); #2;
    push(0, 1'b1, 8'h0A); push(3, 1'b1, 8'h3A);
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b1000);
    exp_wr.push_back(8'h0A); exp_wr.push_back(8'h3A);
    drain(100);

    // Owner 1 goes quiet after one beat while producer 2 waits
    do_reset();
    @(posedge clk); #2;
    push(1, 1'b0, 8'h1B); push(2, 1'b1, 8'h2B);
    exp_grant.push_back(4'b0010);
    exp_wr.push_back(8'h1B);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    exp_grant.push_back(4'b0100);
    exp_wr.push_back(8'h2B);
    wait_write(8'h1B);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (timeout_evt === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("timeout_evt", seen, 1);
    drain(100);
`else
    wait_write(8'h1B);
    bad = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant !== 4'b0010 || wr !== 1'b0) bad++;
    end
    chk("grant_held", bad, 0);
    @(posedge clk); #2;
    push(1, 1'b1, 8'h1C);
    exp_wr.push_back(8'h1C); exp_wr.push_back(8'h2B);
    exp_grant.push_back(4'b0100);
    drain(100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
